// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, load/store and memory-side handshake signals of the shared memory port
interface mem_port_arbiter_if #(parameter int XLEN = 64);
    logic            if_req_valid;
    logic            if_req_ready;
    logic [XLEN-1:0] if_addr;
    logic            if_rsp_valid;
    logic [XLEN-1:0] if_rsp_data;
    logic            ls_req_valid;
    logic            ls_req_ready;
    logic            ls_wen;
    logic [XLEN-1:0] ls_addr;
    logic [XLEN-1:0] ls_wdata;
    logic [7:0]      ls_wmask;
    logic            ls_rsp_valid;
    logic [XLEN-1:0] ls_rsp_data;
    logic            mem_req_valid;
    logic            mem_req_ready;
    logic            mem_wen;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [7:0]      mem_wmask;
    logic            mem_rsp_valid;
    logic [XLEN-1:0] mem_rsp_data;
    modport slave (
        input  if_req_valid, if_addr, ls_req_valid, ls_wen, ls_addr, ls_wdata, ls_wmask,
               mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output if_req_ready, if_rsp_valid, if_rsp_data, ls_req_ready, ls_rsp_valid, ls_rsp_data,
               mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask
    );
    modport master (
        output if_req_valid, if_addr, ls_req_valid, ls_wen, ls_addr, ls_wdata, ls_wmask,
               mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  if_req_ready, if_rsp_valid, if_rsp_data, ls_req_ready, ls_rsp_valid, ls_rsp_data,
               mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and load/store, LS priority with fetch starvation limit
module mem_port_arbiter #(
    parameter int XLEN       = 64,
    parameter int STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_port_arbiter_if.slave    bus,
    output logic                 busy,
    output logic                 protocol_err
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
    localparam logic [3:0] LP_MAX = 4'(STARVE_MAX);
    state_t          r_state, w_next;
    logic            r_owner_ls, r_wen, r_if_rsp_valid, r_ls_rsp_valid, r_err;
    logic [XLEN-1:0] r_addr, r_wdata, r_if_rsp_data, r_ls_rsp_data;
    logic [7:0]      r_mask;
    logic [3:0]      r_streak;
    logic            w_idle, w_grant_ls, w_grant_if, w_rsp;
    logic [XLEN-1:0] w_addr;
    always_comb begin
        w_idle     = r_state == IDLE;
        w_grant_ls = w_idle & bus.ls_req_valid & ~(bus.if_req_valid & (r_streak == LP_MAX));
        w_grant_if = w_idle & bus.if_req_valid & ~w_grant_ls;
        w_rsp      = (r_state == WAIT) & bus.mem_rsp_valid;
        w_addr     = w_grant_ls ? bus.ls_addr : bus.if_addr;
        w_next     = r_state;
        case (r_state)
            IDLE:    w_next = (w_grant_ls | w_grant_if) ? REQ : IDLE;
            REQ:     w_next = bus.mem_req_ready ? WAIT : REQ;
            default: w_next = bus.mem_rsp_valid ? IDLE : WAIT;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_owner_ls     <= 1'b0;
            r_wen          <= 1'b0;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_mask         <= '0;
            r_streak       <= '0;
            r_if_rsp_valid <= 1'b0;
            r_ls_rsp_valid <= 1'b0;
            r_if_rsp_data  <= '0;
            r_ls_rsp_data  <= '0;
            r_err          <= 1'b0;
        end else begin
            r_state        <= w_next;
            r_if_rsp_valid <= w_rsp & ~r_owner_ls;
            r_ls_rsp_valid <= w_rsp & r_owner_ls;
            if (w_rsp && r_owner_ls)
                r_ls_rsp_data <= r_wen ? '0 : bus.mem_rsp_data;
            if (w_rsp && !r_owner_ls)
                r_if_rsp_data <= bus.mem_rsp_data;
            // a response outside WAIT has no owner: flag it and drop it
            if (bus.mem_rsp_valid && r_state != WAIT)
                r_err <= 1'b1;
            if (w_grant_ls || w_grant_if) begin
                r_owner_ls <= w_grant_ls;
                r_wen      <= w_grant_ls & bus.ls_wen;
                r_addr     <= {w_addr[XLEN-1:3], 3'b000};
                r_wdata    <= w_grant_ls ? bus.ls_wdata : '0;
                r_mask     <= (w_grant_ls & bus.ls_wen) ? bus.ls_wmask : '0;
                r_streak   <= (w_grant_ls & bus.if_req_valid) ? ((r_streak == LP_MAX) ? LP_MAX : r_streak + 4'd1) : '0;
            end
        end
    end
    assign bus.if_req_ready  = w_grant_if;
    assign bus.ls_req_ready  = w_grant_ls;
    assign bus.if_rsp_valid  = r_if_rsp_valid;
    assign bus.if_rsp_data   = r_if_rsp_data;
    assign bus.ls_rsp_valid  = r_ls_rsp_valid;
    assign bus.ls_rsp_data   = r_ls_rsp_data;
    assign bus.mem_req_valid = r_state == REQ;
    assign bus.mem_wen       = r_wen;
    assign bus.mem_addr      = r_addr;
    assign bus.mem_wdata     = r_wdata;
    assign bus.mem_wmask     = r_mask;
    assign busy              = ~w_idle;
    assign protocol_err      = r_err;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized transactions checked against a transaction-level arbitration model
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic busy, protocol_err;
    always #5 clk = ~clk;
    mem_port_arbiter_if #(.XLEN(64)) bus();
    mem_port_arbiter #(.XLEN(64), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst), .bus(bus), .busy(busy), .protocol_err(protocol_err)
    );
    int n_chk = 0, n_err = 0;
    int streak;
    bit err_exp, pif, pls, ls_w;
    logic [63:0] if_a, ls_a, ls_d, last_if, last_ls;
    logic [7:0] ls_m;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic drive_req();
        bus.if_req_valid = pif;
        bus.if_addr      = if_a;
        bus.ls_req_valid = pls;
        bus.ls_wen       = ls_w;
        bus.ls_addr      = ls_a;
        bus.ls_wdata     = ls_d;
        bus.ls_wmask     = ls_m;
    endtask
    task automatic new_if();
        pif  = 1;
        if_a = {$urandom, $urandom};
    endtask
    task automatic new_ls();
        pls  = 1;
        ls_w = 1'($urandom_range(0, 1));
        ls_a = {$urandom, $urandom};
        ls_d = {$urandom, $urandom};
        ls_m = 8'($urandom);
    endtask
    task automatic model_reset();
        streak = 0; pif = 0; pls = 0; last_if = '0; last_ls = '0;
    endtask
    task automatic run_txn(input int k, input int d, input logic [63:0] rd, output bit g_ls);
        logic [63:0] e_addr, e_wd, e_rsp;
        logic [7:0] e_m;
        bit e_wen;
        drive_req();
        #1;
        g_ls = pls && !(pif && streak == 4);
        chk("if_req_ready", bus.if_req_ready, !g_ls && pif);
        chk("ls_req_ready", bus.ls_req_ready, g_ls);
        chk("busy_idle", busy, 0);
        e_addr = (g_ls ? ls_a : if_a) & ~64'h7;
        e_wen  = g_ls && ls_w;
        e_wd   = ls_d;
        e_m    = e_wen ? ls_m : 8'h0;
        e_rsp  = e_wen ? 64'h0 : rd;
        if (g_ls) begin
            streak = pif ? ((streak < 4) ? streak + 1 : 4) : 0;
            pls = 0;
        end else begin
            streak = 0;
            pif = 0;
        end
        @(negedge clk);
        drive_req();
        for (int i = 0; i <= k; i++) begin
            #1;
            chk("mem_req_valid", bus.mem_req_valid, 1);
            chk("mem_addr", bus.mem_addr, e_addr);
            chk("mem_wen", bus.mem_wen, e_wen);
            chk("mem_wmask", bus.mem_wmask, e_m);
            if (e_wen) chk("mem_wdata", bus.mem_wdata, e_wd);
            chk("busy_req", busy, 1);
            chk("readies_req", {bus.if_req_ready, bus.ls_req_ready}, 0);
            chk("rsp_valid_req", {bus.if_rsp_valid, bus.ls_rsp_valid}, 0);
            chk("if_rsp_hold", bus.if_rsp_data, last_if);
            chk("ls_rsp_hold", bus.ls_rsp_data, last_ls);
            bus.mem_req_ready = (i == k);
            @(negedge clk);
        end
        bus.mem_req_ready = 0;
        for (int i = 0; i <= d; i++) begin
            #1;
            chk("mem_req_valid_wait", bus.mem_req_valid, 0);
            chk("busy_wait", busy, 1);
            if (i == d) begin
                bus.mem_rsp_valid = 1;
                bus.mem_rsp_data  = rd;
            end
            @(negedge clk);
        end
        bus.mem_rsp_valid = 0;
        bus.mem_rsp_data  = {$urandom, $urandom};
        if (g_ls) last_ls = e_rsp; else last_if = e_rsp;
        #1;
        chk("if_rsp_valid", bus.if_rsp_valid, !g_ls);
        chk("ls_rsp_valid", bus.ls_rsp_valid, g_ls);
        chk("if_rsp_data", bus.if_rsp_data, last_if);
        chk("ls_rsp_data", bus.ls_rsp_data, last_ls);
        chk("protocol_err", protocol_err, err_exp);
        #1;
    endtask
    initial begin
        bit g;
        logic [5:0] order;
        pif = 0; pls = 0; ls_w = 0; if_a = '0; ls_a = '0; ls_d = '0; ls_m = '0;
        err_exp = 0;
        bus.mem_req_ready = 0; bus.mem_rsp_valid = 0; bus.mem_rsp_data = '0;
        drive_req();
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        model_reset();
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_err", protocol_err, 0);
        chk("rst_mem_req_valid", bus.mem_req_valid, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wmask", bus.mem_wmask, 0);
        chk("rst_rsp", {bus.if_rsp_valid, bus.ls_rsp_valid}, 0);
        chk("rst_rsp_data", bus.if_rsp_data | bus.ls_rsp_data, 0);
        @(negedge clk);
        pls = 1; ls_w = 0; ls_a = 64'h8000_000C; ls_d = '0; ls_m = 8'hFF;
        run_txn(0, 0, 64'h1122334455667788, g);
        pls = 1; ls_w = 1; ls_a = 64'h8000_0010; ls_d = 64'hDEADBEEF; ls_m = 8'h0F;
        run_txn(3, 1, 64'hFFFF_0000_FFFF_0000, g);
        order = '0;
        for (int t = 0; t < 6; t++) begin
            if (!pif) new_if();
            if (!pls) new_ls();
            run_txn(int'($urandom_range(0, 1)), 0, {$urandom, $urandom}, g);
            order = {order[4:0], g};
        end
        chk("starve_order", order, 6'b111101);
        pif = 0;
        drive_req();
        @(negedge clk);
        @(negedge clk);
        pls = 1; ls_w = 0; ls_a = 64'h1000; new_if();
        drive_req();
        @(negedge clk);
        bus.mem_req_ready = 1;
        @(negedge clk);
        bus.mem_req_ready = 0;
        rst = 1;
        @(negedge clk);
        rst = 0;
        model_reset();
        drive_req();
        @(negedge clk);
        @(negedge clk);
        bus.mem_rsp_valid = 1;
        bus.mem_rsp_data  = 64'hABCD;
        @(negedge clk);
        bus.mem_rsp_valid = 0;
        err_exp = 1;
        #1;
        chk("late_rsp_valid", {bus.if_rsp_valid, bus.ls_rsp_valid}, 0);
        chk("late_err", protocol_err, 1);
        chk("late_busy", busy, 0);
        chk("late_rsp_data", bus.ls_rsp_data, 0);
        @(negedge clk);
        for (int t = 0; t < 150; t++) begin
            if (!pif && $urandom_range(0, 1) == 1) new_if();
            if (!pls && $urandom_range(0, 1) == 1) new_ls();
            if (!pif && !pls) new_ls();
            run_txn(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), {$urandom, $urandom}, g);
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one memory port between instruction fetch (IF, read-only) and load/store (LS, read/write with byte mask).
- One outstanding transaction at a time; valid/ready request handshake on both sides; response on the memory side is a single-cycle pulse.
- Fixed LS-over-IF priority with a starvation limit so fetch always makes progress.
- Sits between the IF/LS stages and the memory bus, replacing their direct memory accesses.

Parameters:
- XLEN, 64, data/address width.
- STARVE_MAX, 4, consecutive LS grants allowed while IF is waiting before IF is forced (1..15).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- if_req_valid  in  1  fetch request
- if_req_ready  out  1  fetch request accepted this cycle
- if_addr  in  XLEN  fetch byte address
- if_rsp_valid  out  1  fetch response pulse
- if_rsp_data  out  XLEN  fetch read data (aligned doubleword)
- ls_req_valid  in  1  load/store request
- ls_req_ready  out  1  load/store request accepted this cycle
- ls_wen  in  1  1 = store, 0 = load
- ls_addr  in  XLEN  load/store byte address
- ls_wdata  in  XLEN  store data, already lane-positioned
- ls_wmask  in  8  store byte-enable
- ls_rsp_valid  out  1  load/store response pulse (stores get an ack)
- ls_rsp_data  out  XLEN  load data; 0 for stores
- mem_req_valid  out  1  memory request
- mem_req_ready  in  1  memory accepts request
- mem_wen  out  1  write enable
- mem_addr  out  XLEN  doubleword-aligned address
- mem_wdata  out  XLEN  write data
- mem_wmask  out  8  byte-enable; 0 for reads
- mem_rsp_valid  in  1  memory response pulse
- mem_rsp_data  in  XLEN  read data
- busy  out  1  high whenever state != IDLE
- protocol_err  out  1  sticky error flag

Behaviour:
- Reset: rst high at a clock edge forces the following, regardless of state:
  - state = IDLE; streak counter = 0.
  - All registered outputs = 0, including *_rsp_valid, *_rsp_data, mem_* and protocol_err.
  - Any in-flight transaction is dropped; no response is delivered for it.
- States: IDLE, REQ, WAIT.
- IDLE:
  - Grant is combinational. grant_ls = ls_req_valid & !(if_req_valid & streak == STARVE_MAX). grant_if = if_req_valid & !grant_ls.
  - if_req_ready = grant_if and ls_req_ready = grant_ls, asserted only in IDLE; both are 0 in every other state.
  - On a grant, capture owner, wen, addr & ~7, wdata, and mask (mask forced to 0 for reads and for IF), then go to REQ.
- REQ:
  - mem_req_valid = 1, with mem_* driven from the captured registers.
  - All mem_* values stay stable until mem_req_ready.
  - When mem_req_ready is high, go to WAIT.
- WAIT:
  - mem_req_valid = 0.
  - On mem_rsp_valid: next cycle, pulse the owner's *_rsp_valid for exactly 1 cycle.
  - Response data = mem_rsp_data for reads, 0 for stores. The non-owner's rsp_valid stays 0.
  - Go to IDLE at the same edge.
  - rsp_data registers hold their value until the next response.
- Minimum latency:
  - Cycle 0: accept.
  - Cycle 1: mem_req_valid, mem_req_ready.
  - Cycle 2: mem_rsp_valid.
  - Cycle 3: *_rsp_valid. IDLE in cycle 3, so a new request can be accepted in cycle 3.
- Streak counter, 4 bits, updated at each grant:
  - LS grant with if_req_valid high: increment, saturating at STARVE_MAX.
  - LS grant with if_req_valid low: clear to 0.
  - IF grant: clear to 0.
- protocol_err:
  - Set if mem_rsp_valid is seen in IDLE or REQ; the response is ignored.
  - Cleared only by rst. A late response after reset mid-operation therefore sets it.
- Request inputs sampled outside IDLE are ignored. Requesters must hold valid and payload until ready.

Test Plan:
- Single LS load: ls_addr=0x8000_000C, mem_req_ready=1, mem_rsp_valid one cycle later with 0x1122334455667788.
  - Required: mem_addr=0x8000_0008, mem_wmask=0, ls_rsp_valid pulse at cycle 3 with that data, if_rsp_valid stays 0.
- Store: ls_wen=1, ls_addr=0x8000_0010, ls_wmask=0x0F, ls_wdata=0xDEADBEEF; mem_req_ready held 0 for 3 cycles.
  - Required: mem_req_valid and payload stable for 4 cycles, mem_wmask=0x0F.
  - Required: ls_rsp_valid pulse with data 0; busy high for the whole transaction.
- Simultaneous requests in IDLE: if_req_valid=ls_req_valid=1.
  - Required: ls_req_ready=1, if_req_ready=0; IF is granted after the LS transaction completes.
- Starvation, STARVE_MAX=4: IF and LS held valid continuously.
  - Required: grant order LS, LS, LS, LS, IF, LS...; streak returns to 0 after the IF grant.
- Reset mid-op: rst asserted in WAIT, then mem_rsp_valid arrives 2 cycles after rst deasserts.
  - Required: no *_rsp_valid pulse, protocol_err=1, state IDLE, next request served normally.
- Back-to-back: a new IF request is accepted in the cycle ls_rsp_valid pulses.
  - Required: if_req_ready=1 in that cycle, mem_req_valid=1 next cycle.
